// File: rtl/wb_bram_responder.sv
// wb_bram_responder: Wishbone slave over a 2**AW x 32 block RAM, every transfer answered DELAY cycles after its request.
// Define WB_BRAM_RESPONDER_ERR_EN to answer out-of-window requests with wbs_err_o instead of a null ack.
module wb_bram_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
  parameter int AW = 10,
  parameter int DELAY = 10
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic [31:0] wbs_dat_o
);
`ifdef WB_BRAM_RESPONDER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state;
  logic [7:0] cnt;
  logic [AW-1:0] idx;
  logic we, hit, err_q;
  logic [3:0] sel;
  logic [31:0] wdat;
  logic [31:0] mem [0:(1<<AW)-1];
  logic req, in_range, unused_adr;
  logic [AW-1:0] r_idx;
  logic r_we, r_hit, go_resp;
  assign req = wbs_cyc_i & wbs_stb_i;
  assign in_range = wbs_adr_i[31:AW+2] == BASE_ADDR[31:AW+2];
  assign unused_adr = ^wbs_adr_i[1:0];
  assign wbs_err_o = ERR_EN & err_q;
  // With DELAY==1 the response is launched straight from IDLE, so the live request stands in for the latched one.
  always_comb begin
    r_idx = (state == S_IDLE) ? wbs_adr_i[AW+1:2] : idx;
    r_we = (state == S_IDLE) ? wbs_we_i : we;
    r_hit = (state == S_IDLE) ? in_range : hit;
    go_resp = req & ((state == S_IDLE && DELAY == 1) || (state == S_WAIT && cnt == 8'd1));
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state <= S_IDLE;
      cnt <= '0;
      idx <= '0;
      we <= 1'b0;
      hit <= 1'b0;
      sel <= '0;
      wdat <= '0;
      wbs_ack_o <= 1'b0;
      err_q <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= 1'b0;
      err_q <= 1'b0;
      wbs_dat_o <= '0;
      if (state == S_IDLE && req) begin
        idx <= wbs_adr_i[AW+1:2];
        we <= wbs_we_i;
        hit <= in_range;
        sel <= wbs_sel_i;
        wdat <= wbs_dat_i;
      end
      if (go_resp) begin
        state <= S_RESP;
        cnt <= '0;
        wbs_ack_o <= !ERR_EN || r_hit;
        err_q <= ERR_EN && !r_hit;
        wbs_dat_o <= (r_hit && !r_we) ? mem[r_idx] : '0;
      end else begin
        case (state)
          S_IDLE: if (req) begin
            state <= S_WAIT;
            cnt <= 8'(DELAY - 1);
          end
          S_WAIT: if (!req) begin
            state <= S_IDLE;
            cnt <= '0;
          end else cnt <= cnt - 8'd1;
          default: state <= S_IDLE;
        endcase
      end
    end
  end
  // The RAM has no reset; a write lands at the end of its RESP cycle, which reset cancels by leaving RESP.
  always_ff @(posedge wb_clk_i) begin
    if (state == S_RESP && we && hit)
      for (int i = 0; i < 4; i++)
        if (sel[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];
  end
endmodule

// File: tb/tb_wb_bram_responder.sv
// tb_wb_bram_responder: table vectors, hand-written corner sequences and a randomized run against an array model.
module tb_wb_bram_responder;
  localparam int DELAY = 10;
`ifdef WB_BRAM_RESPONDER_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic clk = 1'b0, rst_n, cyc, stb, we;
  logic [3:0] sel;
  logic [31:0] adr, wdat, dat_o;
  logic ack_o, err_o;
  int total = 0, bad = 0;
  wb_bram_responder #(.BASE_ADDR(32'h3800_0000), .AW(10), .DELAY(DELAY)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack_o), .wbs_err_o(err_o), .wbs_dat_o(dat_o));
  always #5 clk = ~clk;
  typedef struct {
    bit w;
    logic [31:0] a;
    logic [3:0] s;
    logic [31:0] d;
    logic [31:0] exp;
    bit oor;
  } vec_t;
  vec_t vq[$];
  logic [31:0] mdl [0:1023];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic xfer(input bit w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                      output logic ack, output logic err, output logic [31:0] rd, output int lat);
    int quiet = 0;
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; adr = a; sel = s; wdat = d;
    lat = 0; ack = 0; err = 0; rd = '0;
    while (!(ack || err) && lat < 300) begin
      @(posedge clk); lat++;
      @(negedge clk);
      ack = ack_o; err = err_o; rd = dat_o;
      if (!(ack || err) && dat_o !== 32'h0) quiet++;
    end
    cyc = 0; stb = 0;
    chk("dat_quiet", quiet, 0);
  endtask
  task automatic expect_silence(input string name, input int cycles);
    int seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (ack_o !== 1'b0 || err_o !== 1'b0 || dat_o !== 32'h0) seen++;
    end
    chk(name, seen, 0);
  endtask
  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic k, e;
    logic [31:0] r;
    int l;
    xfer(1'b0, a, 4'hF, 32'h0, k, e, r, l);
    chk({name, "_lat"}, l, DELAY);
    chk({name, "_ack"}, k, 1);
    chk({name, "_dat"}, r, exp);
  endtask
  task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    logic k, e;
    logic [31:0] r;
    int l;
    xfer(1'b1, a, s, d, k, e, r, l);
    chk("wr_ack", k, 1);
  endtask
  initial begin
    logic k, e;
    logic [31:0] r, a, exp;
    int l, n, last, quiet, ix;
    bit w, o;
    logic [3:0] s;
    logic [31:0] d;
    rst_n = 0; cyc = 0; stb = 0; we = 0; sel = '0; adr = '0; wdat = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", ack_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_dat", dat_o, 0);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_ack", ack_o, 0);
    vq.push_back(vec_t'{1, 32'h3800_0100, 4'hF, 32'hDEAD_BEEF, 32'h0, 0});
    vq.push_back(vec_t'{0, 32'h3800_0100, 4'hF, 32'h0, 32'hDEAD_BEEF, 0});
    vq.push_back(vec_t'{1, 32'h3800_0200, 4'hF, 32'h1122_3344, 32'h0, 0});
    vq.push_back(vec_t'{1, 32'h3800_0200, 4'h5, 32'hAABB_CCDD, 32'h0, 0});
    vq.push_back(vec_t'{0, 32'h3800_0200, 4'hF, 32'h0, 32'h11BB_33DD, 0});
    vq.push_back(vec_t'{1, 32'h3800_0200, 4'h0, 32'hFFFF_FFFF, 32'h0, 0});
    vq.push_back(vec_t'{0, 32'h3800_0203, 4'hF, 32'h0, 32'h11BB_33DD, 0});
    vq.push_back(vec_t'{1, 32'h3800_0200, 4'hA, 32'h9988_7766, 32'h0, 0});
    vq.push_back(vec_t'{0, 32'h3800_0201, 4'hF, 32'h0, 32'h99BB_77DD, 0});
    vq.push_back(vec_t'{1, 32'h3800_0FFC, 4'hF, 32'hCAFE_F00D, 32'h0, 0});
    vq.push_back(vec_t'{1, 32'h3800_0000, 4'hF, 32'h0102_0304, 32'h0, 0});
    vq.push_back(vec_t'{0, 32'h3800_0FFC, 4'hF, 32'h0, 32'hCAFE_F00D, 0});
    vq.push_back(vec_t'{0, 32'h3800_0000, 4'hF, 32'h0, 32'h0102_0304, 0});
    vq.push_back(vec_t'{1, 32'h3800_1000, 4'hF, 32'h1234_5678, 32'h0, 1});
    vq.push_back(vec_t'{0, 32'h3800_1000, 4'hF, 32'h0, 32'h0, 1});
    vq.push_back(vec_t'{1, 32'h37FF_FFFC, 4'hF, 32'h5555_5555, 32'h0, 1});
    vq.push_back(vec_t'{0, 32'h3800_0000, 4'hF, 32'h0, 32'h0102_0304, 0});
    vq.push_back(vec_t'{0, 32'h3800_0FFC, 4'hF, 32'h0, 32'hCAFE_F00D, 0});
    foreach (vq[i]) begin
      xfer(vq[i].w, vq[i].a, vq[i].s, vq[i].d, k, e, r, l);
      chk($sformatf("v%0d_lat", i), l, DELAY);
      chk($sformatf("v%0d_ack", i), k, !(ERR && vq[i].oor));
      chk($sformatf("v%0d_err", i), e, ERR && vq[i].oor);
      chk($sformatf("v%0d_dat", i), r, vq[i].exp);
    end
    // write aborted by dropping stb in cycle 4
    wr(32'h3800_0104, 4'hF, 32'hA5A5_A5A5);
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 1; adr = 32'h3800_0104; sel = 4'hF; wdat = 32'h5;
    repeat (4) @(posedge clk);
    #1; cyc = 0; stb = 0;
    expect_silence("abort_silent", 15);
    rd_chk("abort_keep", 32'h3800_0104, 32'hA5A5_A5A5);
    // reset during the ack cycle of a read clears the outputs at once
    wr(32'h3800_0108, 4'hF, 32'h3C3C_3C3C);
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; adr = 32'h3800_0108; sel = 4'hF;
    repeat (DELAY) @(posedge clk);
    @(negedge clk);
    chk("resp_ack", ack_o, 1);
    chk("resp_dat", dat_o, 32'h3C3C_3C3C);
    #1; rst_n = 0; cyc = 0; stb = 0;
    #1;
    chk("async_ack", ack_o, 0);
    chk("async_dat", dat_o, 0);
    @(negedge clk); rst_n = 1;
    // reset in cycle 5 of a write discards it
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 1; adr = 32'h3800_0108; sel = 4'hF; wdat = 32'hFFFF_FFFF;
    repeat (5) @(posedge clk);
    #1; rst_n = 0; cyc = 0; stb = 0;
    #1;
    chk("rst_wait_ack", ack_o, 0);
    chk("rst_wait_err", err_o, 0);
    chk("rst_wait_dat", dat_o, 0);
    @(negedge clk); rst_n = 1;
    expect_silence("rst_silent", 15);
    rd_chk("rst_keep", 32'h3800_0108, 32'h3C3C_3C3C);
    // burst of 11 reads with stb held high
    for (int i = 0; i < 11; i++) wr(32'h3800_0100 + 32'(i) * 4, 4'hF, 32'hB000_0000 + 32'(i) * 32'h0001_0203);
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = 32'h3800_0100;
    n = 0; last = 0; quiet = 0;
    for (int c = 1; c <= 200 && n < 11; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack_o === 1'b1) begin
        chk($sformatf("burst%0d_dat", n), dat_o, 32'hB000_0000 + 32'(n) * 32'h0001_0203);
        chk($sformatf("burst%0d_gap", n), c - last, (n == 0) ? DELAY : DELAY + 1);
        last = c; n++;
        adr = adr + 32'h4;
        if (n == 11) begin
          cyc = 0; stb = 0;
        end
      end else if (dat_o !== 32'h0) quiet++;
    end
    chk("burst_count", n, 11);
    chk("burst_quiet", quiet, 0);
    // randomized traffic against the array model
    for (int i = 512; i < 528; i++) begin
      d = $urandom;
      wr(32'h3800_0000 + 32'(i) * 4, 4'hF, d);
      mdl[i] = d;
    end
    for (int t = 0; t < 60; t++) begin
      w = 1'($urandom_range(0, 1));
      o = ($urandom_range(0, 4) == 0);
      ix = 512 + $urandom_range(0, 15);
      s = 4'($urandom_range(0, 15));
      d = $urandom;
      a = o ? (($urandom_range(0, 1) != 0 ? 32'h3900_0000 : 32'h37F0_0000) | (32'($urandom_range(0, 1023)) << 2))
            : (32'h3800_0000 | (32'(ix) << 2) | 32'($urandom_range(0, 3)));
      exp = (!w && !o) ? mdl[ix] : 32'h0;
      xfer(w, a, s, d, k, e, r, l);
      chk($sformatf("rnd%0d_lat", t), l, DELAY);
      chk($sformatf("rnd%0d_ack", t), k, !(ERR && o));
      chk($sformatf("rnd%0d_err", t), e, ERR && o);
      chk($sformatf("rnd%0d_dat", t), r, exp);
      if (w && !o)
        for (int b = 0; b < 4; b++)
          if (s[b]) mdl[ix][8*b +: 8] = d[8*b +: 8];
    end
    for (int i = 512; i < 528; i++) rd_chk($sformatf("final%0d", i), 32'h3800_0000 + 32'(i) * 4, mdl[i]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
